// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions for alu_control and exec_unit: operation codes,
// execute-stage FSM encoding and an op classification helper.
package rv_alu_pkg;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SLL  = 5'd4;
  localparam logic [4:0] ALU_SRL  = 5'd5;
  localparam logic [4:0] ALU_SRA  = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } exec_state_e;

  function automatic logic is_shift(input logic [4:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Upstream (decoded op) and downstream (EX/MEM result) handshake bundle of
// the execute stage. master = pipeline around the stage, slave = exec_unit.
interface exec_unit_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_alu_control;
  logic            in_regwrite;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_op_a;
  logic [XLEN-1:0] in_op_b;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_regwrite;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, in_alu_control, in_regwrite, in_rd, in_op_a, in_op_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_regwrite, out_rd
  );

  modport slave (
    input  in_valid, in_alu_control, in_regwrite, in_rd, in_op_a, in_op_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_regwrite, out_rd
  );

endinterface

// File: rtl/serial_shifter.sv
// Iterative one-bit-per-cycle shifter used by exec_unit when the barrel
// shifter (EXEC_BARREL_SHIFT_EN) is not built. Loaded with a non-zero shift
// amount; done pulses in the cycle the last bit is shifted, and that cycle's
// result output carries the final value.
module serial_shifter
  import rv_alu_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  logic [4:0]         code,
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  exec_state_e        state_r;
  exec_state_e        state_nxt_s;
  logic [XLEN-1:0]    work_r;
  logic [XLEN-1:0]    step_s;
  logic [SHAMT_W-1:0] cnt_r;
  logic [4:0]         code_r;
  logic               last_s;

  assign last_s = (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1});

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next state: leave SHIFT on the final bit or on an abort
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nxt_s = ST_SHIFT; else state_nxt_s = ST_IDLE;
      ST_SHIFT: if (flush || last_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_SHIFT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs; a flush suppresses the completion pulse
  always_comb begin
    busy   = (state_r == ST_SHIFT);
    done   = (state_r == ST_SHIFT) && last_s && !flush;
    result = step_s;
  end

  // One-bit step of the working register; SRA replicates the sign bit
  always_comb begin
    step_s = work_r;
    case (code_r)
      ALU_SLL: step_s = {work_r[XLEN-2:0], 1'b0};
      ALU_SRL: step_s = {1'b0, work_r[XLEN-1:1]};
      ALU_SRA: step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
      default: step_s = work_r;
    endcase
  end

  // Working register and remaining-bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      work_r <= {XLEN{1'b0}};
      cnt_r  <= {SHAMT_W{1'b0}};
      code_r <= 5'd0;
    end else if (start) begin
      work_r <= data;
      cnt_r  <= shamt;
      code_r <= code;
    end else if (state_r == ST_SHIFT) begin
      if (flush) begin
        cnt_r <= {SHAMT_W{1'b0}};
      end else begin
        work_r <= step_s;
        cnt_r  <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage downstream of alu_control. Computes the ALU result into an
// EX/MEM output register with valid/ready on both sides. Shifts run through
// serial_shifter (shamt+1 cycles) unless EXEC_BARREL_SHIFT_EN is defined, in
// which case a combinational barrel shifter gives every op latency 1.
module exec_unit
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        busy,
  exec_unit_if.slave  bus
);

  localparam int              SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};

  logic               in_ready_s;
  logic               accept_s;
  logic               idle_s;
  logic               load_direct_s;
  logic               load_s;
  logic               shift_done_s;
  logic [XLEN-1:0]    shift_res_s;
  logic [4:0]         pend_rd_s;
  logic               pend_regwrite_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [XLEN-1:0]    alu_s;
  logic [XLEN-1:0]    load_result_s;
  logic [4:0]         load_rd_s;
  logic               load_regwrite_s;

  logic               valid_r;
  logic [XLEN-1:0]    result_r;
  logic               zero_r;
  logic               regwrite_r;
  logic [4:0]         rd_r;

  assign shamt_s = bus.in_op_b[SHAMT_W-1:0];

  // Input handshake: accept only when idle with room downstream and no flush/reset
  always_comb begin
    in_ready_s = idle_s && (!valid_r || bus.out_ready) && !flush && !rst;
    accept_s   = bus.in_valid && in_ready_s;
  end

  // Single-cycle ALU; unused codes produce 0
  always_comb begin
    alu_s = ZERO_X;
    case (bus.in_alu_control)
      ALU_AND:  alu_s = bus.in_op_a & bus.in_op_b;
      ALU_OR:   alu_s = bus.in_op_a | bus.in_op_b;
      ALU_ADD:  alu_s = bus.in_op_a + bus.in_op_b;
      ALU_SUB:  alu_s = bus.in_op_a - bus.in_op_b;
      ALU_XOR:  alu_s = bus.in_op_a ^ bus.in_op_b;
      ALU_SLT:  alu_s = ($signed(bus.in_op_a) < $signed(bus.in_op_b)) ? ONE_X : ZERO_X;
      ALU_SLTU: alu_s = (bus.in_op_a < bus.in_op_b) ? ONE_X : ZERO_X;
`ifdef EXEC_BARREL_SHIFT_EN
      ALU_SLL:  alu_s = bus.in_op_a << shamt_s;
      ALU_SRL:  alu_s = bus.in_op_a >> shamt_s;
      ALU_SRA:  alu_s = $signed(bus.in_op_a) >>> shamt_s;
`else
      // Only shamt=0 shifts complete here; the rest go through the serial path
      ALU_SLL, ALU_SRL, ALU_SRA: alu_s = bus.in_op_a;
`endif
      default:  alu_s = ZERO_X;
    endcase
  end

`ifdef EXEC_BARREL_SHIFT_EN
  assign idle_s          = 1'b1;
  assign busy            = 1'b0;
  assign load_direct_s   = accept_s;
  assign shift_done_s    = 1'b0;
  assign shift_res_s     = ZERO_X;
  assign pend_rd_s       = 5'd0;
  assign pend_regwrite_s = 1'b0;
`else
  logic       shift_start_s;
  logic       shift_busy_s;
  logic [4:0] pend_rd_r;
  logic       pend_regwrite_r;

  assign shift_start_s   = accept_s && is_shift(bus.in_alu_control) && (shamt_s != {SHAMT_W{1'b0}});
  assign load_direct_s   = accept_s && !shift_start_s;
  assign idle_s          = !shift_busy_s;
  assign busy            = shift_busy_s;
  assign pend_rd_s       = pend_rd_r;
  assign pend_regwrite_s = pend_regwrite_r;

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (shift_start_s),
    .code   (bus.in_alu_control),
    .data   (bus.in_op_a),
    .shamt  (shamt_s),
    .busy   (shift_busy_s),
    .done   (shift_done_s),
    .result (shift_res_s)
  );

  // Hold rd/regwrite of the op being shifted until it completes
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd_r       <= 5'd0;
      pend_regwrite_r <= 1'b0;
    end else if (shift_start_s) begin
      pend_rd_r       <= bus.in_rd;
      pend_regwrite_r <= bus.in_regwrite;
    end
  end
`endif

  // Select what loads into the output register: finished shift or direct op
  always_comb begin
    if (shift_done_s) begin
      load_result_s   = shift_res_s;
      load_rd_s       = pend_rd_s;
      load_regwrite_s = pend_regwrite_s;
    end else begin
      load_result_s   = alu_s;
      load_rd_s       = bus.in_rd;
      load_regwrite_s = bus.in_regwrite;
    end
    load_s = load_direct_s || shift_done_s;
  end

  // EX/MEM output register: flush beats load, load may replace a draining result
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      result_r   <= ZERO_X;
      zero_r     <= 1'b0;
      regwrite_r <= 1'b0;
      rd_r       <= 5'd0;
    end else if (flush) begin
      valid_r    <= 1'b0;
    end else if (load_s) begin
      valid_r    <= 1'b1;
      result_r   <= load_result_s;
      zero_r     <= (load_result_s == ZERO_X);
      regwrite_r <= load_regwrite_s;
      rd_r       <= load_rd_s;
    end else if (bus.out_ready) begin
      valid_r    <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = valid_r;
  assign bus.out_result   = result_r;
  assign bus.out_zero     = zero_r;
  assign bus.out_regwrite = regwrite_r;
  assign bus.out_rd       = rd_r;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vectors, randomized ops against
// an arithmetic reference model, shift timing, backpressure, flush and reset.
module tb_exec_unit;

  localparam int XLEN = 32;
`ifdef EXEC_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  exec_unit_if #(.XLEN(XLEN)) bus ();

  exec_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference ALU from the op definitions
  function automatic logic [31:0] ref_alu(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh  = int'(b % 32'd32);
    ext = {{32{a[31]}}, a} >> sh;
    case (code)
      5'd0:    return a & b;
      5'd1:    return a | b;
      5'd2:    return a + b;
      5'd3:    return a - b;
      5'd4:    return a << sh;
      5'd5:    return a >> sh;
      5'd6:    return ext[31:0];
      5'd7:    return a ^ b;
      5'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10:   return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference latency: cycles from the accept edge until out_valid is seen
  function automatic int ref_latency(input logic [4:0] code, input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32'd32);
    if (BARREL) return 1;
    if (code == 5'd4 || code == 5'd5 || code == 5'd6) return int'(sh) + 1;
    return 1;
  endfunction

  task automatic drive_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic rw);
    bus.in_valid       = 1'b1;
    bus.in_alu_control = code;
    bus.in_op_a        = a;
    bus.in_op_b        = b;
    bus.in_rd          = rd;
    bus.in_regwrite    = rw;
  endtask

  // Issue one op (out_ready held high) and wait for its result, bounded
  task automatic run_one(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw,
                         output int lat, output logic [31:0] res, output logic zero,
                         output logic [4:0] rdo, output logic rwo, output logic to);
    int n;
    to = 1'b0;
    n  = 0;
    #1;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    drive_op(code, a, b, rd, rw);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid) begin
      if (lat >= 40) begin
        to = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    res  = bus.out_result;
    zero = bus.out_zero;
    rdo  = bus.out_rd;
    rwo  = bus.out_regwrite;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready} !== 42'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b result=%h zero=%b rd=%0d rw=%b busy=%b in_ready=%b, required all 0",
               bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[13] = '{
      '{5'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1},
      '{5'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1},
      '{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1},
      '{5'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1},
      '{5'd8,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1},
      '{5'd6,  32'h80000000, 32'h00000004, 32'hF8000000, 5},
      '{5'd4,  32'h12345678, 32'h00000000, 32'h12345678, 1},
      '{5'd5,  32'h80000000, 32'h0000001F, 32'h00000001, 32},
      '{5'd4,  32'h00000001, 32'h0000001F, 32'h80000000, 32},
      '{5'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1},
      '{5'd7,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1},
      '{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1},
      '{5'd6,  32'h7FFFFFFF, 32'h00000023, 32'h0FFFFFFF, 4}
    };
    int lat, exp_lat;
    logic [31:0] res;
    logic zero, rwo, to, rw;
    logic [4:0] rdo, rd;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      rd = 5'(i + 3);
      rw = (i % 2 == 0);
      exp_lat = BARREL ? 1 : tbl[i].lat;
      run_one(tbl[i].code, tbl[i].a, tbl[i].b, rd, rw, lat, res, zero, rdo, rwo, to);
      vectors++;
      if (to || res !== tbl[i].exp || zero !== (tbl[i].exp == 32'd0) || rdo !== rd || rwo !== rw) begin
        miscompares++;
        $display("FAIL directed_%0d: result=%h zero=%b rd=%0d rw=%b timeout=%b, required result=%h zero=%b rd=%0d rw=%b",
                 i, res, zero, rdo, rwo, to, tbl[i].exp, (tbl[i].exp == 32'd0), rd, rw);
      end
      vectors++;
      if (lat !== exp_lat) begin
        miscompares++;
        $display("FAIL directed_latency_%0d: got %0d required %0d", i, lat, exp_lat);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] valid_codes[10] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd9, 5'd10};
    logic [4:0] code, rd, rdo;
    logic [31:0] a, b, exp, res;
    logic rw, rwo, zero, to;
    int lat, sel;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sel  = $urandom_range(0, 11);
      code = (sel < 10) ? valid_codes[sel] : 5'($urandom_range(8, 31));
      a    = $urandom;
      b    = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      rd   = 5'($urandom);
      rw   = 1'($urandom);
      exp  = ref_alu(code, a, b);
      run_one(code, a, b, rd, rw, lat, res, zero, rdo, rwo, to);
      vectors++;
      if (to || res !== exp || zero !== (exp == 32'd0) || rdo !== rd || rwo !== rw) begin
        miscompares++;
        $display("FAIL random_%0d code=%0d a=%h b=%h: result=%h zero=%b rd=%0d rw=%b timeout=%b, required result=%h rd=%0d rw=%b",
                 i, code, a, b, res, zero, rdo, rwo, to, exp, rd, rw);
      end
      vectors++;
      if (lat !== ref_latency(code, b)) begin
        miscompares++;
        $display("FAIL random_latency_%0d code=%0d: got %0d required %0d", i, code, lat, ref_latency(code, b));
      end
    end
  endtask

  task automatic test_shift_busy();
    bus.out_ready = 1'b1;
    #1;
    drive_op(5'd6, 32'h80000000, 32'd4, 5'd9, 1'b1);
    tick();
    drive_op(5'd2, 32'd1, 32'd1, 5'd10, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      #1;
      vectors++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL shift_busy_cycle%0d: busy=%b in_ready=%b out_valid=%b, required 1 0 0", k, busy, bus.in_ready, bus.out_valid);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== 32'hF8000000 || bus.out_rd !== 5'd9) begin
      miscompares++;
      $display("FAIL shift_done_cycle5: busy=%b valid=%b result=%h rd=%0d, required 0 1 f8000000 9",
               busy, bus.out_valid, bus.out_result, bus.out_rd);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL shift_no_extra_op: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] a, b, exp;
    logic [4:0] code;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a    = $urandom;
      b    = $urandom;
      code = (i % 3 == 0) ? 5'd2 : ((i % 3 == 1) ? 5'd3 : 5'd7);
      drive_op(code, a, b, 5'(i), 1'b1);
      exp_q.push_back(ref_alu(code, a, b));
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_in_ready_%0d: got %b required 1", i, bus.in_ready);
      end
      tick();
      exp = exp_q.pop_front();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp || bus.out_rd !== 5'(i)) begin
        miscompares++;
        $display("FAIL b2b_result_%0d: valid=%b result=%h rd=%0d, required 1 %h %0d", i, bus.out_valid, bus.out_result, bus.out_rd, exp, i);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ea, eb, ec, a, b;
    bus.out_ready = 1'b0;
    a = $urandom; b = $urandom; ea = a + b;
    drive_op(5'd2, a, b, 5'd1, 1'b1);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_first_ready: got %b required 1", bus.in_ready);
    end
    tick();
    a = $urandom; b = $urandom; eb = a + b;
    drive_op(5'd2, a, b, 5'd2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== ea || bus.out_rd !== 5'd1) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: in_ready=%b valid=%b result=%h rd=%0d, required 0 1 %h 1", k, bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd, ea);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release_ready: got %b required 1", bus.in_ready);
    end
    tick();
    a = $urandom; b = $urandom; ec = a + b;
    drive_op(5'd2, a, b, 5'd3, 1'b1);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== eb || bus.out_rd !== 5'd2) begin
      miscompares++;
      $display("FAIL bp_stream_b: valid=%b result=%h rd=%0d, required 1 %h 2", bus.out_valid, bus.out_result, bus.out_rd, eb);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== ec || bus.out_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL bp_stream_c: valid=%b result=%h rd=%0d, required 1 %h 3", bus.out_valid, bus.out_result, bus.out_rd, ec);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drained: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    bit seen;
    bus.out_ready = 1'b1;
    if (!BARREL) begin
      // Abort a long SRL mid-way
      #1;
      drive_op(5'd5, $urandom, 32'd20, 5'd4, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 9; k++) tick();
      flush = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_in_ready: got %b required 0", bus.in_ready);
      end
      tick();
      flush = 1'b0;
      vectors++;
      if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_abort: busy=%b out_valid=%b, required 0 0", busy, bus.out_valid);
      end
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
        tick();
        if (bus.out_valid) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
        miscompares++;
        $display("FAIL flush_no_result: out_valid seen=%b required 0", seen);
      end
      // Flush in the completion cycle of a 3-bit SLL
      drive_op(5'd4, 32'h0000000F, 32'd3, 5'd5, 1'b1);
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      seen = bus.out_valid;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.out_valid) seen = 1'b1;
      end
      vectors++;
      if (seen) begin
        miscompares++;
        $display("FAIL flush_beats_done: out_valid seen=%b required 0", seen);
      end
    end
    // Op presented together with flush is dropped
    drive_op(5'd2, 32'd7, 32'd8, 5'd6, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    seen = bus.out_valid;
    tick();
    if (bus.out_valid) seen = 1'b1;
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL flush_drops_op: out_valid seen=%b required 0", seen);
    end
    // Flush clears a held result
    bus.out_ready = 1'b0;
    drive_op(5'd1, 32'h00F0, 32'h0F00, 5'd7, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clears_held: out_valid=%b required 0", bus.out_valid);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.out_ready = 1'b1;
    drive_op(5'd5, 32'hDEADBEEF, 32'd20, 5'd8, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready} !== 42'd0) begin
      miscompares++;
      $display("FAIL rst_mid_shift: valid=%b result=%h zero=%b rd=%0d rw=%b busy=%b in_ready=%b, required all 0",
               bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_shift_ready: got %b required 1", bus.in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_mid_shift_no_result: out_valid seen=%b required 0", seen);
    end
    // Reset with a held valid result
    bus.out_ready = 1'b0;
    drive_op(5'd2, 32'd3, 32'd4, 5'd11, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd7) begin
      miscompares++;
      $display("FAIL rst_setup_valid: valid=%b result=%h, required 1 00000007", bus.out_valid, bus.out_result);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready} !== 42'd0) begin
      miscompares++;
      $display("FAIL rst_with_valid: valid=%b result=%h zero=%b rd=%0d rw=%b busy=%b in_ready=%b, required all 0",
               bus.out_valid, bus.out_result, bus.out_zero, bus.out_rd, bus.out_regwrite, busy, bus.in_ready);
    end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_with_valid_ready: got %b required 1", bus.in_ready);
    end
  endtask

  initial begin
    rst                = 1'b1;
    flush              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_alu_control = 5'd0;
    bus.in_regwrite    = 1'b0;
    bus.in_rd          = 5'd0;
    bus.in_op_a        = 32'd0;
    bus.in_op_b        = 32'd0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_directed();
    test_random();
    if (!BARREL) test_shift_busy();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage that sits directly downstream of alu_control.
- Accepts a decoded operation: 5-bit ALU code, regwrite, rd, and two operands.
- Computes the result and holds it in an EX/MEM output register with valid/ready handshakes on both sides.
- Shifts run iteratively, one bit per cycle, through a small FSM; all other ops complete in one cycle.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, $clog2(XLEN), shift-amount width (derived localparam, not overridable).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream op valid.
- in_ready  output  1  block can accept an op this cycle.
- in_alu_control  input  5  ALU code (AND=0 OR=1 ADD=2 SUB=3 SLL=4 SRL=5 SRA=6 XOR=7 SLT=9 SLTU=10).
- in_regwrite  input  1  regwrite from alu_control, passed through.
- in_rd  input  5  destination register, passed through.
- in_op_a  input  XLEN  operand A.
- in_op_b  input  XLEN  operand B; shift amount = in_op_b[SHAMT_W-1:0].
- out_valid  output  1  result register holds a valid op.
- out_ready  input  1  downstream consumes the result.
- out_result  output  XLEN  ALU result.
- out_zero  output  1  out_result == 0.
- out_regwrite  output  1  registered regwrite.
- out_rd  output  5  registered rd.
- busy  output  1  FSM is in SHIFT.

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE, shift counter 0. in_ready is 1 the cycle after reset deasserts.
- Accept condition: accept = in_valid && in_ready, where in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Non-shift ops: result is registered on the accept edge, so out_valid is high the next cycle (latency 1).
  - ADD/SUB: mod 2^XLEN.
  - SLT: signed compare; SLTU: unsigned compare; each yields 0 or 1 zero-extended.
- Unused codes (8, 11-31): result 0, out_zero 1, rd and regwrite still passed through.
- Shifts (SLL/SRL/SRA): on accept, load the working register with op_a and the counter with shamt, then enter SHIFT.
  - In SHIFT, each cycle shifts one bit (SRA replicates the sign bit) and decrements the counter.
  - When the counter is 0, the result loads into the output register and the FSM returns to IDLE.
  - shamt=0: completes without entering SHIFT, latency 1.
  - General latency: shamt+1 cycles (shamt=31 gives 32 cycles).
- States: IDLE and SHIFT.
  - IDLE to SHIFT: accept of a shift op with shamt != 0.
  - SHIFT to IDLE: counter reaches 0, or flush.
- Output register: holds value and valid until out_ready is sampled high. A new result may load in the same cycle as the old one drains (back-to-back throughput of 1 op/cycle for non-shift ops).
- out_zero is computed from the registered result, not combinationally from inputs.
- Flush:
  - Clears out_valid and aborts any shift in progress; the FSM returns to IDLE.
  - An op presented in the flush cycle is dropped (in_ready is low).
  - Flush wins over completion and over accept.
- rst mid-shift: same effect as flush, plus all registers cleared.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: EXEC_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. Every op has latency 1, the SHIFT state is not built, and busy is tied 0.
- Undefined: the iterative shifter described above.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package rv_alu_pkg:
  - ALU code localparams (AND..SLTU), shared with alu_control.
  - FSM state encoding (IDLE=0, SHIFT=1).
  - Helper function is_shift(code).
- Sub-module: serial_shifter, holding the working register, counter, and done pulse; replaced by the barrel logic under EXEC_BARREL_SHIFT_EN.

Test Plan:
- ADD a=0x7FFFFFFF b=1, out_ready=1 -> next cycle out_valid=1, result 0x80000000, out_zero=0. SUB a=5 b=5 -> result 0, out_zero=1.
- SLT a=0xFFFFFFFF b=1 -> result 1; SLTU with the same operands -> result 0; code 8 -> result 0, regwrite and rd passed through.
- SRA a=0x80000000 shamt=4 -> busy for 4 cycles, in_ready=0 throughout, out_valid on cycle 5, result 0xF8000000. SLL shamt=0 -> latency 1.
- Backpressure: out_ready=0 with 3 ADD ops offered -> first result held, in_ready=0, second op held at input. Raise out_ready -> results stream one per cycle in order.
- Flush during SRL shamt=20 at cycle 10 -> out_valid stays 0, state IDLE next cycle, no result ever emitted. A flush coinciding with in_valid drops that op.
- Reset asserted mid-shift and with out_valid=1 -> all outputs 0 next cycle, in_ready=1 the cycle after rst deasserts.
